multadd_residual_divider: RTL and testbench

// Inverse of the DSP MULTADD "add shifted A to mult output" path: takes a 38-bit
// z result, removes the (a << acc_fir) term and recovers the multiplicand by

---
 rtl/multadd_residual_divider.sv | 162 ++++++++++++++++
 tb/tb_multadd_residual_divider.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multadd_residual_divider.sv
// +--------------------------------------------------------------------------+
// | multadd_residual_divider: strips (a<<acc_fir) from a MULTADD result and  |
// | recovers the multiplicand by restoring division. Rev 1.0                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module multadd_residual_divider #(
  parameter int A_W = 20,
  parameter int D_W = 18,
  parameter int Z_W = 38,
  parameter int S_W = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Z_W-1:0] z_in,
  input  logic [A_W-1:0] a_in,
  input  logic [S_W-1:0] acc_fir,
  input  logic [D_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Z_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero,
  output logic           underflow,
  output logic           busy
);

  localparam int CNT_W = $clog2(Z_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [Z_W-1:0]   res_q, res_d;
  logic [D_W-1:0]   rem_q, rem_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [S_W-1:0]   sh_q, sh_d;
  logic [D_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic             unf_q, unf_d;

  logic [Z_W-1:0]   w_a_ext;
  logic [Z_W-1:0]   w_shifted;
  logic [Z_W:0]     w_sub;
  logic [D_W:0]     w_trial;
  logic             w_ge;
  logic [D_W-1:0]   w_diff;

  always_comb begin
    w_a_ext   = {{(Z_W-A_W){1'b0}}, a_q};
    w_shifted = (32'(sh_q) >= Z_W) ? '0 : (w_a_ext << sh_q);
    // Extra MSB of the subtraction is the borrow, i.e. z < shifted term.
    w_sub     = {1'b0, res_q} - {1'b0, w_shifted};
    // The residual register doubles as the quotient shift register: its MSB
    // feeds the partial remainder while quotient bits enter at the LSB.
    w_trial   = {rem_q, res_q[Z_W-1]};
    w_ge      = (w_trial >= {1'b0, div_q});
    w_diff    = w_trial[D_W-1:0] - div_q;
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    rem_d   = rem_q;
    a_d     = a_q;
    sh_d    = sh_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unf_d   = unf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          res_d   = z_in;
          a_d     = a_in;
          sh_d    = acc_fir;
          div_d   = divisor;
          rem_d   = '0;
          dbz_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        rem_d = '0;
        if (div_q == '0) begin
          res_d   = '1;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else if (w_sub[Z_W]) begin
          res_d   = '0;
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          res_d   = w_sub[Z_W-1:0];
          cnt_d   = CNT_W'(Z_W-1);
          state_d = DIV;
        end
      end
      DIV: begin
        res_d = {res_q[Z_W-2:0], w_ge};
        rem_d = w_ge ? w_diff : w_trial[D_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      res_q   <= '0;
      rem_q   <= '0;
      a_q     <= '0;
      sh_q    <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      a_q     <= a_d;
      sh_q    <= sh_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
      unf_q   <= unf_d;
    end
  end

  // Results are only presented in DONE, so they read as zero everywhere else.
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    busy        = (state_q == PREP) || (state_q == DIV);
    quotient    = out_valid ? res_q : '0;
    remainder   = out_valid ? rem_q : '0;
    div_by_zero = out_valid & dbz_q;
    underflow   = out_valid & unf_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_multadd_residual_divider.sv
// +--------------------------------------------------------------------------+
// | tb_multadd_residual_divider: randomized self-checking bench with an      |
// | arithmetic reference model. Rev 1.0                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multadd_residual_divider;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [37:0] z_in;
  logic [19:0] a_in;
  logic [5:0]  acc_fir;
  logic [17:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [37:0] quotient;
  logic [17:0] remainder;
  logic        div_by_zero;
  logic        underflow;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  multadd_residual_divider dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z_in       (z_in),
    .a_in       (a_in),
    .acc_fir    (acc_fir),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .underflow  (underflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [37:0] z, input logic [19:0] a,
                                input logic [5:0] sh, input logic [17:0] d,
                                output logic [63:0] q, output logic [63:0] r,
                                output logic dz, output logic uf);
    logic [63:0] s;
    s  = (sh >= 6'd38) ? 64'd0 : ((64'(a) << sh) & 64'h3F_FFFF_FFFF);
    dz = 1'b0;
    uf = 1'b0;
    if (d == 18'd0) begin
      dz = 1'b1;
      q  = 64'h3F_FFFF_FFFF;
      r  = 64'd0;
    end else if (64'(z) < s) begin
      uf = 1'b1;
      q  = 64'd0;
      r  = 64'd0;
    end else begin
      q = (64'(z) - s) / 64'(d);
      r = (64'(z) - s) % 64'(d);
    end
  endfunction

  task automatic run_op(input logic [37:0] z, input logic [19:0] a,
                        input logic [5:0] sh, input logic [17:0] d, input int hold);
    logic [63:0] eq, er;
    logic        edz, euf;
    int          lat;
    model(z, a, sh, d, eq, er, edz, euf);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    z_in     = z;
    a_in     = a;
    acc_fir  = sh;
    divisor  = d;
    in_valid = 1'b1;
    lat      = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
      if (lat == 1) check("busy_prep", busy, 1);
    end while (!out_valid && lat < 100);
    check("latency", lat, (edz || euf) ? 2 : 40);
    check("out_valid", out_valid, 1);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, edz);
    check("underflow", underflow, euf);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      z_in     = {6'($urandom), 32'($urandom)};
      divisor  = 18'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_valid", out_valid, 1);
      check("hold_quotient", quotient, eq);
      check("hold_remainder", remainder, er);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_cleared", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("quotient_cleared", quotient, 0);
    check("flags_cleared", {div_by_zero, underflow}, 0);
  endtask

  initial begin
    logic seen_valid;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    z_in      = '0;
    a_in      = '0;
    acc_fir   = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_results", {quotient, remainder}, 0);
    check("rst_flags", {div_by_zero, underflow, busy}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    run_op(38'd4606, 20'd255, 6'd1, 18'd4096, 0);
    run_op(38'd4607, 20'd255, 6'd1, 18'd4096, 0);
    run_op(38'd1073737728, 20'hfffff, 6'd63, 18'd4096, 0);
    run_op(38'd12345, 20'd0, 6'd0, 18'd0, 0);
    run_op(38'd100, 20'd1, 6'd7, 18'd3, 0);
    run_op(38'd4606, 20'd255, 6'd1, 18'd4096, 5);

    // Abort in the middle of division.
    @(negedge clk);
    z_in = 38'd4606; a_in = 20'd255; acc_fir = 6'd1; divisor = 18'd4096;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_results", {quotient, remainder, div_by_zero, underflow}, 0);
    seen_valid = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("abort_no_valid", seen_valid, 0);
    run_op(38'd4606, 20'd255, 6'd1, 18'd4096, 0);

    for (int k = 0; k < 25; k++) begin
      logic [37:0] rz;
      logic [19:0] ra;
      logic [5:0]  rs;
      logic [17:0] rd;
      rz = {6'($urandom), 32'($urandom)};
      ra = 20'($urandom);
      rs = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 17));
      if ($urandom_range(0, 9) == 0) rd = 18'd0;
      else if ($urandom_range(0, 1) == 1) rd = 18'($urandom_range(1, 255));
      else rd = 18'($urandom);
      run_op(rz, ra, rs, rd, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
